riscv_alu_div_arb: RTL and testbench

- Shares one serial divider between two requesters, e.g. the core ALU (port 0) and a coprocessor/APU path (port 1).
- Arbitrates requests round-robin and pre-processes operands: B normalisation shift, B-zero flag and sign gating.
- Sequences the divider load/unload handshake and routes the result back to the owning requester.
- Supports per-requester kill, which drops an in-flight operation by draining the divider.

---
 rtl/riscv_alu_div_arb.sv | 146 ++++++++++++++
 tb/tb_riscv_alu_div_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_div_arb.sv
// Round-robin arbiter sharing one serial divider between two requesters.
// Normalises the divisor up front and routes the result back to its owner.
module riscv_alu_div_arb #(
   parameter int C_WIDTH     = 32,
   parameter int C_LOG_WIDTH = 6
) (
   input  logic                     Clk_CI,
   input  logic                     Rst_RBI,
   input  logic [1:0]               Req_Vld_SI,
   output logic [1:0]               Req_Rdy_SO,
   input  logic [2*C_WIDTH-1:0]     Req_OpA_DI,
   input  logic [2*C_WIDTH-1:0]     Req_OpB_DI,
   input  logic [3:0]               Req_OpCode_DI,
   output logic [1:0]               Rsp_Vld_SO,
   input  logic [1:0]               Rsp_Rdy_SI,
   output logic [C_WIDTH-1:0]       Rsp_Res_DO,
   input  logic [1:0]               Kill_SI,
   output logic [C_WIDTH-1:0]       Div_OpA_DO,
   output logic [C_WIDTH-1:0]       Div_OpB_DO,
   output logic [C_LOG_WIDTH-1:0]   Div_OpBShift_DO,
   output logic                     Div_OpBIsZero_SO,
   output logic                     Div_OpBSign_SO,
   output logic [1:0]               Div_OpCode_DO,
   output logic                     Div_InVld_SO,
   output logic                     Div_OutRdy_SO,
   input  logic                     Div_OutVld_SI,
   input  logic [C_WIDTH-1:0]       Div_Res_DI
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;

   // Leading run length: zeros for unsigned ops, sign copies below the MSB for signed ops.
   function automatic logic [C_LOG_WIDTH-1:0] norm_shift(input logic [C_WIDTH-1:0] b,
                                                         input logic sgn);
      logic [C_LOG_WIDTH-1:0] cnt;
      logic                   ref_bit;
      logic                   run;
      cnt     = '0;
      run     = 1'b1;
      ref_bit = sgn & b[C_WIDTH-1];
      for (int i = C_WIDTH-1; i >= 0; i--) begin
         if (run && !(sgn && i == C_WIDTH-1)) begin
            if (b[i] == ref_bit) cnt = cnt + 1'b1;
            else                 run = 1'b0;
         end
      end
      if (b == '0) cnt = C_LOG_WIDTH'(C_WIDTH-1);
      return cnt;
   endfunction

   state_e                 state;
   logic                   ptr;
   logic                   owner;
   logic                   first_wait;
   logic [C_WIDTH-1:0]     opa;
   logic [C_WIDTH-1:0]     opb;
   logic [C_LOG_WIDTH-1:0] shift;
   logic                   b_zero;
   logic                   b_sign;
   logic [1:0]             opcode;

   logic [1:0]             elig;
   logic                   winner;
   logic                   grant;
   logic [C_WIDTH-1:0]     win_a;
   logic [C_WIDTH-1:0]     win_b;
   logic [1:0]             win_op;
   logic [C_LOG_WIDTH-1:0] win_shift;
   logic                   kill_own;
   logic                   wait_live;
   logic                   rsp_hit;

   assign elig      = Req_Vld_SI & ~Kill_SI;
   assign winner    = (elig == 2'b11) ? ptr : elig[1];
   assign grant     = (state == IDLE) && (elig != 2'b00);
   assign win_a     = winner ? Req_OpA_DI[2*C_WIDTH-1:C_WIDTH] : Req_OpA_DI[C_WIDTH-1:0];
   assign win_b     = winner ? Req_OpB_DI[2*C_WIDTH-1:C_WIDTH] : Req_OpB_DI[C_WIDTH-1:0];
   assign win_op    = winner ? Req_OpCode_DI[3:2] : Req_OpCode_DI[1:0];
   assign win_shift = norm_shift(win_b, win_op[0]);

   assign kill_own  = Kill_SI[owner];
   // The first WAIT cycle overlaps the divider's load; its output is not ours yet.
   assign wait_live = (state == WAIT) && !first_wait;
   assign rsp_hit   = wait_live && Div_OutVld_SI && !kill_own;

   assign Req_Rdy_SO       = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
   assign Rsp_Vld_SO       = rsp_hit ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign Rsp_Res_DO       = Div_Res_DI;
   assign Div_InVld_SO     = (state == ISSUE) && !kill_own;
   assign Div_OutRdy_SO    = (state == DRAIN) || (wait_live && (kill_own || Rsp_Rdy_SI[owner]));
   assign Div_OpA_DO       = opa;
   assign Div_OpB_DO       = opb;
   assign Div_OpBShift_DO  = shift;
   assign Div_OpBIsZero_SO = b_zero;
   assign Div_OpBSign_SO   = b_sign;
   assign Div_OpCode_DO    = opcode;

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         owner      <= 1'b0;
         first_wait <= 1'b0;
         opa        <= '0;
         opb        <= '0;
         shift      <= '0;
         b_zero     <= 1'b0;
         b_sign     <= 1'b0;
         opcode     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  opa    <= win_a;
                  opb    <= win_b << win_shift;
                  shift  <= win_shift;
                  b_zero <= (win_b == '0);
                  b_sign <= win_op[0] & win_b[C_WIDTH-1];
                  opcode <= win_op;
                  owner  <= winner;
                  ptr    <= ~winner;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               first_wait <= 1'b1;
               state      <= kill_own ? IDLE : WAIT;
            end
            WAIT: begin
               first_wait <= 1'b0;
               if (kill_own) begin
                  // A result landing in the kill cycle is swallowed right here.
                  state <= (wait_live && Div_OutVld_SI) ? IDLE : DRAIN;
               end else if (rsp_hit && Rsp_Rdy_SI[owner]) begin
                  state <= IDLE;
               end
            end
            DRAIN: begin
               if (Div_OutVld_SI) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_alu_div_arb.sv
// Directed bench for riscv_alu_div_arb with a behavioural serial divider attached.
module tb_riscv_alu_div_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_vld = '0;
   logic [1:0]  req_rdy;
   logic [63:0] req_opa = '0;
   logic [63:0] req_opb = '0;
   logic [3:0]  req_op = '0;
   logic [1:0]  rsp_vld;
   logic [1:0]  rsp_rdy = 2'b11;
   logic [31:0] rsp_res;
   logic [1:0]  kill = '0;
   logic [31:0] div_opa;
   logic [31:0] div_opb;
   logic [5:0]  div_shift;
   logic        div_zero;
   logic        div_sign;
   logic [1:0]  div_op;
   logic        div_in_vld;
   logic        div_out_rdy;
   logic        div_out_vld;
   logic [31:0] div_res;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   riscv_alu_div_arb #(.C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
      .Clk_CI(clk), .Rst_RBI(rst_n),
      .Req_Vld_SI(req_vld), .Req_Rdy_SO(req_rdy),
      .Req_OpA_DI(req_opa), .Req_OpB_DI(req_opb), .Req_OpCode_DI(req_op),
      .Rsp_Vld_SO(rsp_vld), .Rsp_Rdy_SI(rsp_rdy), .Rsp_Res_DO(rsp_res),
      .Kill_SI(kill),
      .Div_OpA_DO(div_opa), .Div_OpB_DO(div_opb), .Div_OpBShift_DO(div_shift),
      .Div_OpBIsZero_SO(div_zero), .Div_OpBSign_SO(div_sign), .Div_OpCode_DO(div_op),
      .Div_InVld_SO(div_in_vld), .Div_OutRdy_SO(div_out_rdy),
      .Div_OutVld_SI(div_out_vld), .Div_Res_DI(div_res)
   );

   // Divider: undo the normalisation, then produce the RISC-V result.
   function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] bsh,
                                           input logic [5:0] sh, input logic zero,
                                           input logic [1:0] op);
      logic [31:0] b;
      b = op[0] ? 32'($signed(bsh) >>> sh) : (bsh >> sh);
      if (zero) b = '0;
      case (op)
         2'd0:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'd2:    return (b == 0) ? a : a % b;
         2'd1: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'($signed(a) / $signed(b));
         end
         default: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
      endcase
   endfunction

   logic       dv_busy;
   logic [6:0] dv_cnt;
   logic [31:0] dv_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_busy <= 1'b0;
         dv_cnt  <= '0;
         dv_res  <= '0;
      end else if (div_in_vld) begin
         dv_busy <= 1'b1;
         dv_cnt  <= 7'(div_shift) + 7'd1;
         dv_res  <= div_ref(div_opa, div_opb, div_shift, div_zero, div_op);
      end else if (dv_busy) begin
         if (dv_cnt != 0)      dv_cnt  <= dv_cnt - 7'd1;
         else if (div_out_rdy) dv_busy <= 1'b0;
      end
   end

   assign div_out_vld = dv_busy && (dv_cnt == 0);
   assign div_res     = dv_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request and returns in its ISSUE cycle (cycle 1).
   task automatic request(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, output int waited);
      if (p == 0) begin
         req_opa[31:0] = a; req_opb[31:0] = b; req_op[1:0] = op;
      end else begin
         req_opa[63:32] = a; req_opb[63:32] = b; req_op[3:2] = op;
      end
      req_vld[p] = 1'b1;
      #1;
      waited = 0;
      while (!req_rdy[p] && waited < 100) begin
         tick();
         waited++;
      end
      chk("grant", {31'b0, req_rdy[p]}, 32'd1);
      tick();
      req_vld[p] = 1'b0;
   endtask

   // Waits for the response on port p; cyc is the cycle index relative to the grant.
   task automatic wait_rsp(input int p, output int cyc);
      logic wrong;
      wrong = 1'b0;
      cyc = 1;
      while (!rsp_vld[p] && cyc < 200) begin
         if (rsp_vld[1-p]) wrong = 1'b1;
         tick();
         cyc++;
      end
      chk("rsp_vld", {31'b0, rsp_vld[p]}, 32'd1);
      chk("rsp_other_port", {31'b0, wrong | rsp_vld[1-p]}, 32'd0);
   endtask

   int   w;
   int   cyc;
   int   exp_port;
   int   gport;
   logic bad;
   logic [31:0] held;

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_req_rdy", {30'b0, req_rdy}, 32'd0);
      chk("rst_rsp_vld", {30'b0, rsp_vld}, 32'd0);
      chk("rst_in_vld", {31'b0, div_in_vld}, 32'd0);
      chk("rst_out_rdy", {31'b0, div_out_rdy}, 32'd0);
      chk("rst_opb", div_opb, 32'd0);
      rst_n = 1'b1;
      tick();

      // Port0 udiv 100/7
      request(0, 32'd100, 32'd7, 2'd0, w);
      chk("udiv_opb", div_opb, 32'hE000_0000);
      chk("udiv_shift", {26'b0, div_shift}, 32'd29);
      chk("udiv_in_vld", {31'b0, div_in_vld}, 32'd1);
      wait_rsp(0, cyc);
      chk("udiv_latency", cyc, 32'd32);
      chk("udiv_res", rsp_res, 32'd14);
      tick();

      // Port1 rem -7/2
      request(1, 32'hFFFF_FFF9, 32'd2, 2'd3, w);
      chk("rem_sign", {31'b0, div_sign}, 32'd0);
      chk("rem_shift", {26'b0, div_shift}, 32'd29);
      chk("rem_opb", div_opb, 32'h4000_0000);
      wait_rsp(1, cyc);
      chk("rem_res", rsp_res, 32'hFFFF_FFFF);
      tick();

      // Port0 div -7/2
      request(0, 32'hFFFF_FFF9, 32'd2, 2'd1, w);
      wait_rsp(0, cyc);
      chk("div_res", rsp_res, 32'hFFFF_FFFD);
      tick();

      // Divide by zero
      request(0, 32'd5, 32'd0, 2'd0, w);
      chk("udiv0_zero", {31'b0, div_zero}, 32'd1);
      chk("udiv0_shift", {26'b0, div_shift}, 32'd31);
      wait_rsp(0, cyc);
      chk("udiv0_latency", cyc, 32'd34);
      chk("udiv0_res", rsp_res, 32'hFFFF_FFFF);
      tick();
      request(1, 32'd5, 32'd0, 2'd2, w);
      chk("urem0_zero", {31'b0, div_zero}, 32'd1);
      wait_rsp(1, cyc);
      chk("urem0_res", rsp_res, 32'd5);
      tick();

      // Both ports valid every cycle: grants alternate
      req_opa = {32'd9, 32'd100};
      req_opb = {32'd3, 32'd7};
      req_op  = 4'b0000;
      req_vld = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_port = k % 2;
         chk("rr_single_grant", {31'b0, ^req_rdy}, 32'd1);
         gport = req_rdy[1] ? 1 : 0;
         chk("rr_port", gport, exp_port);
         tick();
         wait_rsp(gport, cyc);
         chk("rr_res", rsp_res, (gport == 1) ? 32'd3 : 32'd14);
         tick();
      end
      req_vld = 2'b00;

      // Kill of the owner while waiting
      request(0, 32'd100, 32'd7, 2'd0, w);
      tick();
      tick();
      tick();
      kill[0] = 1'b1;
      #1;
      chk("kill_rsp_vld", {30'b0, rsp_vld}, 32'd0);
      chk("kill_out_rdy", {31'b0, div_out_rdy}, 32'd1);
      tick();
      kill[0] = 1'b0;
      bad = 1'b0;
      cyc = 0;
      while (!div_out_vld && cyc < 100) begin
         if (rsp_vld[0] || !div_out_rdy) bad = 1'b1;
         tick();
         cyc++;
      end
      chk("drain_out_vld", {31'b0, div_out_vld}, 32'd1);
      chk("drain_out_rdy", {31'b0, div_out_rdy}, 32'd1);
      chk("drain_quiet", {31'b0, bad | rsp_vld[0]}, 32'd0);
      tick();
      request(1, 32'd9, 32'd3, 2'd0, w);
      chk("after_drain_wait", w, 32'd0);
      wait_rsp(1, cyc);
      chk("after_drain_res", rsp_res, 32'd3);
      tick();

      // Kill in ISSUE: nothing reaches the divider
      request(0, 32'd100, 32'd7, 2'd0, w);
      kill[0] = 1'b1;
      #1;
      chk("issue_kill_in_vld", {31'b0, div_in_vld}, 32'd0);
      tick();
      kill[0] = 1'b0;
      request(1, 32'd9, 32'd3, 2'd0, w);
      chk("issue_kill_idle", w, 32'd0);
      wait_rsp(1, cyc);
      chk("issue_kill_latency", cyc, 32'd33);
      chk("issue_kill_res", rsp_res, 32'd3);
      tick();

      // Backpressure on port0 with port1 waiting
      rsp_rdy[0] = 1'b0;
      request(0, 32'd9, 32'd3, 2'd0, w);
      req_opa[63:32] = 32'd100; req_opb[63:32] = 32'd7; req_op[3:2] = 2'd0;
      req_vld[1] = 1'b1;
      wait_rsp(0, cyc);
      held = rsp_res;
      chk("bp_res", held, 32'd3);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (!rsp_vld[0] || rsp_res !== held || div_out_rdy || req_rdy[1]) bad = 1'b1;
         tick();
      end
      chk("bp_hold", {31'b0, bad}, 32'd0);
      rsp_rdy[0] = 1'b1;
      #1;
      chk("bp_release_out_rdy", {31'b0, div_out_rdy}, 32'd1);
      chk("bp_release_vld", {31'b0, rsp_vld[0]}, 32'd1);
      tick();
      chk("bp_idle_grant1", {30'b0, req_rdy}, 32'd2);
      tick();
      req_vld[1] = 1'b0;
      wait_rsp(1, cyc);
      chk("bp_port1_res", rsp_res, 32'd14);
      tick();

      // Reset in the middle of an operation
      request(0, 32'd100, 32'd7, 2'd0, w);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_rdy", {31'b0, div_out_rdy}, 32'd0);
      chk("midrst_in_vld", {31'b0, div_in_vld}, 32'd0);
      chk("midrst_opb", div_opb, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      request(1, 32'd9, 32'd3, 2'd0, w);
      chk("midrst_wait", w, 32'd0);
      wait_rsp(1, cyc);
      chk("midrst_res", rsp_res, 32'd3);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
